duft_cmd_sequencer: RTL and testbench
=====================================

Name: duft_cmd_sequencer

Overview:
- Upstream driver for the DUFT ap_ctrl_chain wrapper. Accepts read/write commands over a valid/ready stream and buffers them in a small FIFO.
- Issues one transaction at a time over the ap_ctrl_chain handshake and captures ap_return.
- Returns one response per command, over a valid/ready stream, to the host-side bridge.
- Adds a per-transaction timeout so a hung DUFT never stalls the host.

Parameters:
- CMD_DEPTH, 4, command FIFO entries; power of two, 2 to 16.
- TIMEOUT_CYCLES, 1024, cycles in WAIT without ap_done before an error response; must be at least 8.
- CNT_W, 16, width of the transaction counter.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_addr  in  32  DUFT address.
- cmd_wr_data  in  32  write data.
- cmd_rd_wr  in  1  1 = read, 0 = write.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_data  out  32  ap_return, or 0 on error.
- rsp_rd_wr  out  1  echo of the command type.
- rsp_err  out  1  1 = timeout.
- addr  out  32  to DUFT.
- wr_data  out  32  to DUFT.
- rd_wr  out  1  to DUFT.
- ap_start  out  1  to DUFT.
- ap_continue  out  1  to DUFT.
- ap_ce  out  1  to DUFT.
- ap_done  in  1  from DUFT.
- ap_idle  in  1  from DUFT.
- ap_ready  in  1  from DUFT.
- ap_return  in  32  from DUFT.
- txn_cnt  out  CNT_W  completed transactions.
- err_sticky  out  1  set on any timeout.

Behaviour:
- Reset (async assert, sync release): every output is 0 except cmd_ready=1 and ap_ce=1. FIFO is empty, state is IDLE, timeout counter is 0.
- ap_ce is driven 1 whenever ap_rst_n is high.

Command FIFO:
- Push when cmd_valid && cmd_ready.
- cmd_ready = !full, registered or derived from the count; no push-through when full.
- Simultaneous push and pop while full is not allowed. The pop frees the slot, but cmd_ready is already 0 that cycle.
- Pointers wrap at CMD_DEPTH.

Hold register:
- On pop, the head entry is latched into the {addr, wr_data, rd_wr} output registers.
- These outputs stay stable from the first ap_start cycle until the transaction completes. DUFT samples rd_wr in its ACK state and latches addr/wr_data there.

FSM states: IDLE, START, WAIT, DRAIN.
- IDLE: if the FIFO is non-empty and ap_idle=1, pop the head into the hold registers and go to START.
- START: ap_start=1 for exactly one cycle. Clear the timeout counter. Go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - If ap_done=1 and no response is pending (rsp_valid=0, or rsp_ready=1 this cycle): assert ap_continue=1 combinationally this cycle, load rsp_data=ap_return, rsp_rd_wr=rd_wr, rsp_err=0, set rsp_valid next cycle, increment txn_cnt (wraps at 2^CNT_W), go to IDLE.
  - If ap_done=1 and a response is pending: ap_continue=0 and stay in WAIT. DUFT holds in its DONE state.
  - If the counter reaches TIMEOUT_CYCLES-1 without ap_done: emit a response with rsp_err=1, rsp_data=0, set err_sticky, go to DRAIN. This response is also subject to response-slot availability; wait for the slot if it is occupied.
- DRAIN: ap_continue=1 whenever ap_done=1. No response is produced. Return to IDLE after that ap_done cycle, or when ap_idle=1 with ap_done=0.

Response register:
- Single entry; rsp_valid stays high until rsp_ready.
- rsp_data and rsp_rd_wr are stable while valid.

Latency:
- Read with DUFT nominal timing, with START at cycle t: ap_done at t+3, rsp_valid at t+4.
- Next START no earlier than t+5, since IDLE takes one cycle.
- Write responses carry rsp_data=0, matching DUFT behaviour.

Other rules:
- err_sticky clears only on reset.
- Reset mid-transaction aborts immediately: the FIFO and any response are discarded and ap_start is deasserted asynchronously.
- cmd_ready and rsp_valid have no combinational path from cmd_valid or rsp_ready, except for the WAIT completion condition, which uses rsp_ready.

Test Plan:
- Write {addr=0x10, data=0xA5A5A5A5, rd_wr=0}, then read addr=0x10, with rsp_ready=1 -> two responses in order: {0, wr, err=0} and {0xA5A5A5A5, rd, err=0}; txn_cnt=2; each ap_start is a single-cycle pulse; addr is stable during each transaction.
- Push CMD_DEPTH+1 commands back-to-back while the DUFT is busy -> cmd_ready falls after 4 accepts; all 5 commands complete in order once drained.
- Hold rsp_ready=0 through two reads -> the second transaction stalls in WAIT with ap_done=1 and ap_continue=0; it completes on the first rsp_ready; no data is lost.
- Stub DUFT never asserting ap_done -> at cycle START+TIMEOUT_CYCLES the response is {0, err=1} and err_sticky=1; the sequencer idles.
- Stub DUFT asserting ap_done late, after a timeout -> DRAIN pulses ap_continue; no extra response is produced; the next command proceeds normally.
- Assert ap_rst_n=0 during WAIT -> all outputs return to reset values immediately; the FIFO is empty; the first post-reset command behaves normally.

Source files
------------

// File: rtl/duft_cmd_sequencer.sv
// Host-side driver for the DUFT ap_ctrl_chain wrapper: queues read/write commands,
// runs them one at a time through the handshake and returns one response each.
module duft_cmd_sequencer #(
   parameter int CMD_DEPTH      = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_W          = 16
) (
   input  logic             ap_clk,
   input  logic             ap_rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_addr,
   input  logic [31:0]      cmd_wr_data,
   input  logic             cmd_rd_wr,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic             rsp_rd_wr,
   output logic             rsp_err,
   output logic [31:0]      addr,
   output logic [31:0]      wr_data,
   output logic             rd_wr,
   output logic             ap_start,
   output logic             ap_continue,
   output logic             ap_ce,
   input  logic             ap_done,
   input  logic             ap_idle,
   input  logic             ap_ready,
   input  logic [31:0]      ap_return,
   output logic [CNT_W-1:0] txn_cnt,
   output logic             err_sticky
);
   localparam int PTR_W = $clog2(CMD_DEPTH);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(CMD_DEPTH);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DRAIN} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_fifo_addr [CMD_DEPTH];
   logic [31:0]      r_fifo_data [CMD_DEPTH];
   logic             r_fifo_rw   [CMD_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;
   logic [TMO_W-1:0] r_tmo;
   logic [31:0]      r_addr;
   logic [31:0]      r_wr_data;
   logic             r_rd_wr;
   logic             r_rsp_valid;
   logic [31:0]      r_rsp_data;
   logic             r_rsp_rd_wr;
   logic             r_rsp_err;
   logic [CNT_W-1:0] r_txn_cnt;
   logic             r_err_sticky;

   logic             w_push;
   logic             w_pop;
   logic             w_empty;
   logic             w_slot_free;
   logic [TMO_W-1:0] w_tmo_inc;
   logic             w_tmo_hit;
   logic             w_ld_ok;
   logic             w_ld_err;
   logic             w_unused;

   assign cmd_ready   = (r_count != FULL_CNT);
   assign w_push      = cmd_valid && cmd_ready;
   assign w_empty     = (r_count == '0);
   assign w_slot_free = !r_rsp_valid || rsp_ready;
   // Fires in the WAIT cycle where the counter reaches TIMEOUT_CYCLES-1.
   assign w_tmo_inc   = r_tmo + 1'b1;
   assign w_tmo_hit   = (w_tmo_inc >= TMO_LAST);
   assign w_unused    = ap_ready;

   assign ap_ce      = 1'b1;
   assign addr       = r_addr;
   assign wr_data    = r_wr_data;
   assign rd_wr      = r_rd_wr;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_rd_wr  = r_rsp_rd_wr;
   assign rsp_err    = r_rsp_err;
   assign txn_cnt    = r_txn_cnt;
   assign err_sticky = r_err_sticky;

   always_comb begin
      w_next      = r_state;
      w_pop       = 1'b0;
      w_ld_ok     = 1'b0;
      w_ld_err    = 1'b0;
      ap_start    = 1'b0;
      ap_continue = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && ap_idle) begin
               w_pop  = 1'b1;
               w_next = S_START;
            end
         end
         S_START: begin
            ap_start = 1'b1;
            w_next   = S_WAIT;
         end
         S_WAIT: begin
            // A finished DUFT is held in DONE until the response slot can take its result.
            if (ap_done) begin
               if (w_slot_free) begin
                  ap_continue = 1'b1;
                  w_ld_ok     = 1'b1;
                  w_next      = S_IDLE;
               end
            end else if (w_tmo_hit && w_slot_free) begin
               w_ld_err = 1'b1;
               w_next   = S_DRAIN;
            end
         end
         S_DRAIN: begin
            ap_continue = ap_done;
            if (ap_done || ap_idle) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk) begin
      if (w_push) begin
         r_fifo_addr[r_wr_ptr] <= cmd_addr;
         r_fifo_data[r_wr_ptr] <= cmd_wr_data;
         r_fifo_rw[r_wr_ptr]   <= cmd_rd_wr;
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state   <= S_IDLE;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_tmo     <= '0;
         r_addr    <= '0;
         r_wr_data <= '0;
         r_rd_wr   <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_addr    <= r_fifo_addr[r_rd_ptr];
            r_wr_data <= r_fifo_data[r_rd_ptr];
            r_rd_wr   <= r_fifo_rw[r_rd_ptr];
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (r_state == S_START) begin
            r_tmo <= '0;
         end else if (r_state == S_WAIT && r_tmo != TMO_LAST) begin
            r_tmo <= w_tmo_inc;
         end
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_rsp_valid  <= 1'b0;
         r_rsp_data   <= '0;
         r_rsp_rd_wr  <= 1'b0;
         r_rsp_err    <= 1'b0;
         r_txn_cnt    <= '0;
         r_err_sticky <= 1'b0;
      end else begin
         if (w_ld_ok || w_ld_err) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= w_ld_ok ? ap_return : 32'd0;
            r_rsp_rd_wr <= r_rd_wr;
            r_rsp_err   <= w_ld_err;
         end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
         end
         if (w_ld_ok) begin
            r_txn_cnt <= r_txn_cnt + 1'b1;
         end
         if (w_ld_err) begin
            r_err_sticky <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_duft_cmd_sequencer.sv
// Directed bench for duft_cmd_sequencer driving a behavioural DUFT stub
// whose done latency, hang and busy behaviour are set per test.
`timescale 1ns/1ps
module tb_duft_cmd_sequencer;
   localparam int DEPTH = 4;
   localparam int TMO   = 16;
   localparam int CW    = 16;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [31:0]   cmd_addr;
   logic [31:0]   cmd_wr_data;
   logic          cmd_rd_wr;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [31:0]   rsp_data;
   logic          rsp_rd_wr;
   logic          rsp_err;
   logic [31:0]   addr;
   logic [31:0]   wr_data;
   logic          rd_wr;
   logic          ap_start;
   logic          ap_continue;
   logic          ap_ce;
   logic          ap_done;
   logic          ap_idle;
   logic          ap_ready;
   logic [31:0]   ap_return;
   logic [CW-1:0] txn_cnt;
   logic          err_sticky;

   duft_cmd_sequencer #(
      .CMD_DEPTH     (DEPTH),
      .TIMEOUT_CYCLES(TMO),
      .CNT_W         (CW)
   ) dut (
      .ap_clk     (ap_clk),
      .ap_rst_n   (ap_rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_wr_data(cmd_wr_data),
      .cmd_rd_wr  (cmd_rd_wr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_rd_wr  (rsp_rd_wr),
      .rsp_err    (rsp_err),
      .addr       (addr),
      .wr_data    (wr_data),
      .rd_wr      (rd_wr),
      .ap_start   (ap_start),
      .ap_continue(ap_continue),
      .ap_ce      (ap_ce),
      .ap_done    (ap_done),
      .ap_idle    (ap_idle),
      .ap_ready   (ap_ready),
      .ap_return  (ap_return),
      .txn_cnt    (txn_cnt),
      .err_sticky (err_sticky)
   );

   always #5 ap_clk = ~ap_clk;

   // DUFT stub: done d_delay cycles after ap_start, held until ap_continue.
   int          d_phase = 0;
   int          d_delay = 3;
   logic        d_hang = 1'b0;
   logic        d_force_busy = 1'b0;
   logic [31:0] d_addr;
   logic [31:0] d_wd;
   logic        d_rw;
   logic [31:0] d_mem [64];

   always @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         d_phase <= 0;
      end else if (d_phase == 0) begin
         if (ap_start && !d_hang) begin
            d_phase <= 1;
            d_addr  <= addr;
            d_wd    <= wr_data;
            d_rw    <= rd_wr;
         end
      end else if (d_phase < d_delay) begin
         d_phase <= d_phase + 1;
      end else if (ap_continue) begin
         d_phase <= 0;
         if (!d_rw) d_mem[d_addr[7:2]] <= d_wd;
      end
   end

   assign ap_done   = (d_phase != 0) && (d_phase >= d_delay);
   assign ap_idle   = (d_phase == 0) && !d_force_busy;
   assign ap_ready  = ap_done;
   assign ap_return = (ap_done && d_rw) ? d_mem[d_addr[7:2]] : 32'd0;

   // Observers: start pulses, hold-register stability, continues, accepted responses.
   int          cyc = 0;
   int          last_start = 0;
   int          start_cnt = 0;
   int          start_long = 0;
   int          hold_bad = 0;
   int          cont_cnt = 0;
   logic        prev_start = 1'b0;
   logic [31:0] rq_data[$];
   logic        rq_rw[$];
   logic        rq_err[$];
   int          rq_lat[$];

   always @(posedge ap_clk) begin
      cyc        <= cyc + 1;
      prev_start <= ap_start;
      if (ap_start) begin
         start_cnt  <= start_cnt + 1;
         last_start <= cyc;
      end
      if (ap_start && prev_start) start_long <= start_long + 1;
      if (d_phase != 0 && {addr, wr_data, rd_wr} !== {d_addr, d_wd, d_rw}) hold_bad <= hold_bad + 1;
      if (ap_continue && ap_done) cont_cnt <= cont_cnt + 1;
      if (rsp_valid && rsp_ready) begin
         rq_data.push_back(rsp_data);
         rq_rw.push_back(rsp_rd_wr);
         rq_err.push_back(rsp_err);
         rq_lat.push_back(cyc - last_start);
      end
   end

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic push_cmd(input logic [31:0] a, input logic [31:0] d, input logic rw);
      logic acc;
      acc         = 1'b0;
      cmd_addr    = a;
      cmd_wr_data = d;
      cmd_rd_wr   = rw;
      cmd_valid   = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
         acc = cmd_ready;
         tick();
      end
      cmd_valid = 1'b0;
      chk("push_accept", acc, 1);
   endtask

   task automatic wait_rsp(input int n);
      for (int i = 0; i < 200 && rq_data.size() < n; i++) tick();
      chk("rsp_count", rq_data.size(), n);
   endtask

   task automatic chk_rsp(input int idx, input logic [31:0] d, input logic rw, input logic err,
                          input string tag);
      if (idx < rq_data.size()) begin
         chk({tag, "_data"}, rq_data[idx], d);
         chk({tag, "_rd_wr"}, rq_rw[idx], rw);
         chk({tag, "_err"}, rq_err[idx], err);
      end else begin
         chk({tag, "_present"}, rq_data.size(), idx + 1);
      end
   endtask

   initial begin
      int   c0;
      logic stalled;
      ap_rst_n    = 1'b0;
      cmd_valid   = 1'b0;
      cmd_addr    = '0;
      cmd_wr_data = '0;
      cmd_rd_wr   = 1'b0;
      rsp_ready   = 1'b1;
      repeat (3) tick();
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_ap_ce", ap_ce, 1);
      chk("rst_outs", {rsp_valid, ap_start, ap_continue, err_sticky, rsp_err, rd_wr}, 0);
      chk("rst_addr", addr, 0);
      chk("rst_txn_cnt", txn_cnt, 0);
      ap_rst_n = 1'b1;
      tick();

      // write then read of the same address
      push_cmd(32'h10, 32'hA5A5A5A5, 1'b0);
      push_cmd(32'h10, 32'h0, 1'b1);
      wait_rsp(2);
      chk_rsp(0, 32'h0, 1'b0, 1'b0, "t1_wr");
      chk_rsp(1, 32'hA5A5A5A5, 1'b1, 1'b0, "t1_rd");
      chk("t1_wr_lat", rq_lat[0], 4);
      chk("t1_rd_lat", rq_lat[1], 4);
      chk("t1_txn_cnt", txn_cnt, 2);
      chk("t1_start_cnt", start_cnt, 2);
      chk("t1_start_pulse", start_long, 0);
      chk("t1_hold_stable", hold_bad, 0);

      // fill the FIFO while the DUFT reports busy
      d_force_busy = 1'b1;
      push_cmd(32'h20, 32'h11111111, 1'b0);
      push_cmd(32'h24, 32'h22222222, 1'b0);
      push_cmd(32'h20, 32'h0, 1'b1);
      push_cmd(32'h24, 32'h0, 1'b1);
      chk("t2_full_ready", cmd_ready, 0);
      cmd_addr    = 32'h28;
      cmd_wr_data = 32'h33333333;
      cmd_rd_wr   = 1'b0;
      cmd_valid   = 1'b1;
      repeat (3) tick();
      chk("t2_held_ready", cmd_ready, 0);
      chk("t2_no_start", start_cnt, 2);
      d_force_busy = 1'b0;
      push_cmd(32'h28, 32'h33333333, 1'b0);
      wait_rsp(7);
      chk_rsp(2, 32'h0, 1'b0, 1'b0, "t2_w20");
      chk_rsp(3, 32'h0, 1'b0, 1'b0, "t2_w24");
      chk_rsp(4, 32'h11111111, 1'b1, 1'b0, "t2_r20");
      chk_rsp(5, 32'h22222222, 1'b1, 1'b0, "t2_r24");
      chk_rsp(6, 32'h0, 1'b0, 1'b0, "t2_w28");
      chk("t2_txn_cnt", txn_cnt, 7);
      chk("t2_hold_stable", hold_bad, 0);

      // back-pressure on the response port
      rsp_ready = 1'b0;
      push_cmd(32'h10, 32'h0, 1'b1);
      push_cmd(32'h24, 32'h0, 1'b1);
      stalled = 1'b0;
      for (int i = 0; i < 100 && !stalled; i++) begin
         tick();
         stalled = rsp_valid && ap_done;
      end
      chk("t3_stalled", stalled, 1);
      chk("t3_cont_low", ap_continue, 0);
      chk("t3_rsp_hold_data", rsp_data, 32'hA5A5A5A5);
      repeat (4) tick();
      chk("t3_still_stalled", {rsp_valid, ap_done, ap_continue}, 3'b110);
      chk("t3_rsp_count", rq_data.size(), 7);
      rsp_ready = 1'b1;
      #1;
      chk("t3_cont_on_ready", ap_continue, 1);
      wait_rsp(9);
      chk_rsp(7, 32'hA5A5A5A5, 1'b1, 1'b0, "t3_first");
      chk_rsp(8, 32'h22222222, 1'b1, 1'b0, "t3_second");
      chk("t3_txn_cnt", txn_cnt, 9);

      // DUFT never completes
      d_hang = 1'b1;
      push_cmd(32'h40, 32'h0, 1'b1);
      wait_rsp(10);
      chk_rsp(9, 32'h0, 1'b1, 1'b1, "t4_tmo");
      chk("t4_lat", rq_lat[9], TMO);
      chk("t4_err_sticky", err_sticky, 1);
      chk("t4_txn_cnt", txn_cnt, 9);
      repeat (5) tick();
      chk("t4_idle_starts", start_cnt, 10);
      chk("t4_idle_outs", {rsp_valid, cmd_ready, ap_start}, 3'b010);
      d_hang = 1'b0;

      // DUFT completes only after the timeout has fired
      d_delay = TMO + 4;
      c0 = cont_cnt;
      push_cmd(32'h10, 32'h0, 1'b1);
      wait_rsp(11);
      chk_rsp(10, 32'h0, 1'b1, 1'b1, "t5_tmo");
      for (int i = 0; i < 100 && d_phase != 0; i++) tick();
      chk("t5_drain_cont", cont_cnt - c0, 1);
      repeat (3) tick();
      chk("t5_no_extra_rsp", rq_data.size(), 11);
      d_delay = 3;
      push_cmd(32'h24, 32'h0, 1'b1);
      wait_rsp(12);
      chk_rsp(11, 32'h22222222, 1'b1, 1'b0, "t5_next");
      chk("t5_next_lat", rq_lat[11], 4);
      chk("t5_txn_cnt", txn_cnt, 10);
      chk("t5_err_sticky", err_sticky, 1);

      // reset while a transaction is in WAIT with a second command queued
      d_delay = 10;
      push_cmd(32'h10, 32'h0, 1'b1);
      push_cmd(32'h24, 32'h0, 1'b1);
      for (int i = 0; i < 50 && d_phase != 3; i++) tick();
      chk("t6_in_wait", d_phase, 3);
      ap_rst_n = 1'b0;
      #1;
      chk("t6_ap_start", ap_start, 0);
      chk("t6_outs", {rsp_valid, ap_continue, err_sticky, rd_wr}, 0);
      chk("t6_ready_ce", {cmd_ready, ap_ce}, 2'b11);
      chk("t6_addr", addr, 0);
      chk("t6_txn_cnt", txn_cnt, 0);
      repeat (2) tick();
      ap_rst_n = 1'b1;
      d_delay  = 3;
      repeat (6) tick();
      chk("t6_fifo_empty", start_cnt, 13);
      chk("t6_no_rsp", rq_data.size(), 12);
      push_cmd(32'h10, 32'h0, 1'b1);
      wait_rsp(13);
      chk_rsp(12, 32'hA5A5A5A5, 1'b1, 1'b0, "t6_post");
      chk("t6_post_lat", rq_lat[12], 4);
      chk("t6_post_txn_cnt", txn_cnt, 1);
      chk("t6_start_pulse", start_long, 0);
      chk("t6_hold_stable", hold_bad, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
